// File: rtl/foo_stim_gen.sv
// ---------------------------------------------------------------------------
// foo_stim_gen
//
// Upstream stimulus source for one foo lane. Emits an arithmetic sequence of
// WIDTH-bit operands over a valid/ready handshake. Each run is started by
// 'start', is bounded to COUNT accepted samples, and can be restarted from
// DONE.
//
// Parameters:
//   WIDTH  operand width of 'a'
//   LANE   lane index, scales the first value
//   BASE   first value is (LANE+1)*BASE, truncated to WIDTH
//   STEP   increment between samples, modulo 2^WIDTH
//   COUNT  samples per run (0 means a run finishes without emitting anything)
//
// Ports:
//   clk         in   clock, all state updates on posedge
//   rst         in   asynchronous active-high reset
//   start       in   begin a run (ignored while a run is in progress)
//   ready       in   downstream accepts the current sample
//   valid       out  a / long_in hold a sample
//   a           out  current operand
//   long_in     out  {1'b0, a, a}, combinational from a
//   busy        out  high while a run is in progress
//   done        out  high once a run has completed
//   sent_count  out  samples accepted since the last start
//
// Build option:
//   FOO_STIM_READY_EN  when defined, 'ready' is honoured. When undefined,
//                      'ready' is treated as constant 1 and every valid cycle
//                      is an accepted beat.
// ---------------------------------------------------------------------------
module foo_stim_gen #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned LANE  = 0,
    parameter int unsigned BASE  = 5,
    parameter int unsigned STEP  = 10,
    parameter int unsigned COUNT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               ready,
    output logic               valid,
    output logic [WIDTH-1:0]   a,
    output logic [2*WIDTH:0]   long_in,
    output logic               busy,
    output logic               done,
    output logic [31:0]        sent_count
);

    // Product is formed at WIDTH bits so it wraps exactly like the truncated
    // full-precision value would.
    localparam logic [WIDTH-1:0] FIRST_VAL = WIDTH'(LANE + 1) * WIDTH'(BASE);
    localparam logic [WIDTH-1:0] STEP_VAL  = WIDTH'(STEP);
    localparam logic [31:0]      LAST_IDX  = COUNT - 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             valid_q, valid_d;
    logic [31:0]      sent_q, sent_d;
    logic             ready_eff;
    logic             accept;

`ifdef FOO_STIM_READY_EN
    assign ready_eff = ready;
`else
    // The port stays connected but is forced to "always accept".
    assign ready_eff = ready | 1'b1;
`endif

    assign accept = valid_q & ready_eff;

    // Next-state logic. IDLE and DONE behave identically on start, so a
    // restart from DONE is indistinguishable from a fresh start. Data only
    // move on an accepted beat; a stalled beat leaves everything untouched.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        valid_d = valid_q;
        sent_d  = sent_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sent_d = '0;
                    if (COUNT != 0) begin
                        state_d = ST_RUN;
                        a_d     = FIRST_VAL;
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    if (sent_q != '1) begin
                        sent_d = sent_q + 32'd1;
                    end
                    // The final beat retires the run and leaves 'a' at its
                    // last value rather than advancing past it.
                    if (sent_q == LAST_IDX) begin
                        valid_d = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        a_d = a_q + STEP_VAL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State register; reset discards any partial run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            valid_q <= 1'b0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            valid_q <= valid_d;
            sent_q  <= sent_d;
        end
    end

    assign valid      = valid_q;
    assign a          = a_q;
    assign long_in    = {1'b0, a_q, a_q};
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign sent_count = sent_q;

endmodule
